seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
- Time-multiplexes one shared 7-segment bus across DIGITS display digits.
- Each digit holds a code register (0..CODES-1) that is edited by three push keys:
  - key_a: decrement the digit under the cursor.
  - key_b: increment the digit under the cursor.
  - key_sel: move the cursor.
- Sits between the board keys and the physical segment/digit-enable pins.
- It is the sequencer and owner of the segment bus.

Parameters:
- DIGITS, 4: number of multiplexed digits (2..8).
- CODES, 8: number of valid codes per digit (2..8).
- SCAN_DIV, 1000: clock cycles per digit scan slot (>=2).
- DEBOUNCE_CYCLES, 16: consecutive stable samples required to accept a key level (used only with SEG_KEY_DEBOUNCE_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- key_a  input  1  asynchronous key, press = 1; decrement.
- key_b  input  1  asynchronous key, press = 1; increment.
- key_sel  input  1  asynchronous key, press = 1; advance cursor.
- segments  output  7  registered segment pattern for the active digit.
- digit_en  output  DIGITS  registered one-hot digit enable, active high; all-zero during blanking.
- cursor  output  clog2(DIGITS)  index of the digit being edited.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values:
  - All digit codes = 0; cursor = 0; scan index = 0; prescaler = 0.
  - segments = 7'b0000000; digit_en = 0.
  - Synchronizer, debounce and edge-detect state cleared; no key pulse is generated for a key that is held through reset release.
- Key path, per key:
  - 2-flop synchronizer, then optional debounce, then rising-edge detect.
  - Output is a one-cycle pulse per press; holding a key never auto-repeats.
  - Latency from key_* rising edge to pulse: 3 cycles without debounce.
- Code update (on pulses):
  - a_pulse alone: code[cursor] = (code == 0) ? CODES-1 : code-1.
  - b_pulse alone: code[cursor] = (code == CODES-1) ? 0 : code+1.
  - a_pulse and b_pulse in the same cycle: no change.
  - sel_pulse: cursor = (cursor == DIGITS-1) ? 0 : cursor+1.
  - sel_pulse together with a/b: the edit applies to the old cursor, then the cursor advances.
  - The updated code is visible on segments no earlier than the next slot of that digit.
- Scan sequencing:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - When the prescaler wraps, the scan index advances (DIGITS-1 wraps to 0).
  - Slot cycle 0 (prescaler == 0) is a blanking cycle: digit_en = 0, segments = 0.
  - Slot cycles 1..SCAN_DIV-1: digit_en = one-hot(scan index); segments = SEG_TABLE[code[scan index]].
  - Outputs are registered: 1-cycle latency from prescaler/scan state to the pins.
- SEG_TABLE, codes 0..7: 0000000, 0101010, 1010101, 1110000, 0001111, 1100011, 0011100, 1111111.
- Reset mid-slot: everything returns to its reset value on the next edge; scanning restarts at digit 0 with a blanking cycle.

Optional Feature:
- Macro: SEG_KEY_DEBOUNCE_EN.
- Defined:
  - Each synchronized key passes through a counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive samples that differ from the current accepted level.
  - Any bounce resets the counter.
  - Added latency: DEBOUNCE_CYCLES cycles.
- Undefined: the synchronized level feeds edge detect directly; no counter is instantiated.

Decomposition:
- Package seg_pkg holds:
  - SEG_W = 7.
  - MAX_CODES = 8.
  - The SEG_TABLE constant array.
  - A code_t typedef (3-bit).
- One sub-module: seg_key_conditioner, instantiated three times. It contains the synchronizer, the debounce under the macro, and the rising-edge pulse output.

Test Plan:
- Bench settings: DIGITS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=4.
- Reset: hold rst_n=0 for 3 cycles with key_b=1, then release → segments=0 and digit_en=0 in the first post-reset cycle; no code change while key_b stays high.
- Increment/wrap: 8 clean key_b presses on digit 0 → code steps 1..7,0; during a digit-0 slot, segments reads 0101010 after the first press and 0000000 after the eighth.
- Decrement/wrap: one key_a press from code 0 → code 7, segments 1111111 during digit 0's slot.
- Simultaneous a and b: both rise in the same cycle → no code change; sel together with b at cursor=1 → code[1]=1, cursor=2.
- Scan order: free-run 20 cycles → digit_en sequence per slot is 0000, 0001×3, 0000, 0010×3, ..., wrapping from 1000 back to 0001.
- Debounce (macro on): key_b toggles 1,0,1 with 2-cycle gaps, then stays high for 6 cycles → exactly one increment. Macro off, same stimulus → two increments.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the segment scan controller: segment width, code range
// and the code-to-segment lookup table.
package seg_pkg;

  localparam int SEG_W     = 7;
  localparam int MAX_CODES = 8;

  typedef logic [2:0] code_t;

  localparam logic [SEG_W-1:0] SEG_TABLE [MAX_CODES] = '{
    7'b0000000, 7'b0101010, 7'b1010101, 7'b1110000,
    7'b0001111, 7'b1100011, 7'b0011100, 7'b1111111
  };

endpackage

// File: rtl/seg_key_conditioner.sv
// One push key: 2-flop synchronizer, optional debounce (SEG_KEY_DEBOUNCE_EN)
// and a registered rising-edge detector producing one pulse per press.
module seg_key_conditioner
`ifdef SEG_KEY_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYCLES = 16)
`endif
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_i,
  output logic pulse_o
);

  logic       sync1_q, sync2_q;
  logic       prev_q, prev_d;
  logic       pulse_q, pulse_d;
  logic [1:0] warm_q;
  logic       armed;
  logic       level;

  // Edges are ignored until the synchronizer holds real samples, so a key
  // held through reset release never looks like a fresh press.
  assign armed = (warm_q == 2'd3);

`ifdef SEG_KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    if (!armed) begin
      acc_d = sync2_q;
    end else if (sync2_q != acc_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        acc_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = acc_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    prev_d  = armed ? level : 1'b1;
    pulse_d = armed & level & ~prev_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      warm_q  <= 2'd0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      if (!armed) begin
        warm_q <= warm_q + 2'd1;
      end
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexes one 7-segment bus across DIGITS digits whose codes are edited
// with three keys. SEG_KEY_DEBOUNCE_EN adds a debounce counter to each key.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int CODES           = 8,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_a,
  input  logic                      key_b,
  input  logic                      key_sel,
  output logic [SEG_W-1:0]          segments,
  output logic [DIGITS-1:0]         digit_en,
  output logic [$clog2(DIGITS)-1:0] cursor
);

  localparam int SW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
    $error("DIGITS must be in 2..8");
  end
  if (CODES < 2 || CODES > MAX_CODES) begin : g_bad_codes
    $error("CODES must be in 2..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $error("SCAN_DIV must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic a_pulse, b_pulse, sel_pulse;

`ifdef SEG_KEY_DEBOUNCE_EN
  seg_key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_a (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(key_a), .pulse_o(a_pulse));
  seg_key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_b (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(key_b), .pulse_o(b_pulse));
  seg_key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sel (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(key_sel), .pulse_o(sel_pulse));
`else
  seg_key_conditioner u_key_a (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(key_a), .pulse_o(a_pulse));
  seg_key_conditioner u_key_b (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(key_b), .pulse_o(b_pulse));
  seg_key_conditioner u_key_sel (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(key_sel), .pulse_o(sel_pulse));
`endif

  code_t [DIGITS-1:0] codes_q, codes_d;
  logic  [SW-1:0]     cursor_q, cursor_d;
  logic  [SW-1:0]     scan_q, scan_d;
  logic  [PW-1:0]     pre_q, pre_d;
  logic  [SEG_W-1:0]  seg_q, seg_d;
  logic  [DIGITS-1:0] en_q, en_d;

  always_comb begin
    pre_d  = (pre_q == PW'(SCAN_DIV - 1)) ? '0 : pre_q + 1'b1;
    scan_d = scan_q;
    if (pre_q == PW'(SCAN_DIV - 1)) begin
      scan_d = (scan_q == SW'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end

    // Edits land on the cursor position sampled before any advance.
    codes_d  = codes_q;
    cursor_d = cursor_q;
    if (a_pulse && !b_pulse) begin
      codes_d[cursor_q] = (codes_q[cursor_q] == '0) ? code_t'(CODES - 1)
                                                    : codes_q[cursor_q] - 1'b1;
    end else if (b_pulse && !a_pulse) begin
      codes_d[cursor_q] = (codes_q[cursor_q] == code_t'(CODES - 1)) ? '0
                                                    : codes_q[cursor_q] + 1'b1;
    end
    if (sel_pulse) begin
      cursor_d = (cursor_q == SW'(DIGITS - 1)) ? '0 : cursor_q + 1'b1;
    end

    // Prescaler value 0 is the blanking cycle between digits.
    seg_d = '0;
    en_d  = '0;
    if (pre_q != '0) begin
      en_d[scan_q] = 1'b1;
      seg_d        = SEG_TABLE[codes_q[scan_q]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      codes_q  <= '0;
      cursor_q <= '0;
      scan_q   <= '0;
      pre_q    <= '0;
      seg_q    <= '0;
      en_q     <= '0;
    end else begin
      codes_q  <= codes_d;
      cursor_q <= cursor_d;
      scan_q   <= scan_d;
      pre_q    <= pre_d;
      seg_q    <= seg_d;
      en_q     <= en_d;
    end
  end

  assign segments = seg_q;
  assign digit_en = en_q;
  assign cursor   = cursor_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with a segment/enable scoreboard;
// expectations adapt to SEG_KEY_DEBOUNCE_EN.
module tb_seg_scan_controller;

  localparam int DIGITS   = 4;
  localparam int CODES    = 8;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_a = 1'b0;
  logic       key_b = 1'b0;
  logic       key_sel = 1'b0;
  logic [6:0] segments;
  logic [3:0] digit_en;
  logic [1:0] cursor;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [6:0] pat [8];
  int         mcode [DIGITS];
  int         mcur;
  logic [6:0] sb_seg [$];
  logic [3:0] sb_en [$];

  seg_scan_controller #(
    .DIGITS(DIGITS), .CODES(CODES), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_a(key_a), .key_b(key_b), .key_sel(key_sel),
    .segments(segments), .digit_en(digit_en), .cursor(cursor)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a clean press, update the model, queue the expected pattern of the edited digit.
  task automatic press(input bit a, input bit b, input bit s);
    int d;
    d = mcur;
    key_a = a; key_b = b; key_sel = s;
    tick(8);
    key_a = 1'b0; key_b = 1'b0; key_sel = 1'b0;
    tick(8);
    if (a && !b) mcode[d] = (mcode[d] == 0) ? CODES - 1 : mcode[d] - 1;
    if (b && !a) mcode[d] = (mcode[d] == CODES - 1) ? 0 : mcode[d] + 1;
    if (s) mcur = (mcur == DIGITS - 1) ? 0 : mcur + 1;
    if (a || b) sb_seg.push_back(pat[mcode[d]]);
  endtask

  // Wait for the first cycle of a fresh slot for digit d, then pop and compare.
  task automatic check_slot(input int d, input string tag);
    bit         found;
    bit         prev_blank;
    logic [3:0] oh;
    logic [6:0] exp;
    found = 1'b0;
    prev_blank = 1'b0;
    oh = 4'b0001 << d;
    for (int c = 0; c < 64; c++) begin
      tick(1);
      if (prev_blank && digit_en === oh) begin
        found = 1'b1;
        break;
      end
      prev_blank = (digit_en === 4'b0000);
    end
    chk({tag, "_slot_found"}, {31'd0, found}, 32'd1);
    exp = sb_seg.pop_front();
    chk(tag, {25'd0, segments}, {25'd0, exp});
  endtask

  initial begin
    pat[0] = 7'b0000000; pat[1] = 7'b0101010; pat[2] = 7'b1010101; pat[3] = 7'b1110000;
    pat[4] = 7'b0001111; pat[5] = 7'b1100011; pat[6] = 7'b0011100; pat[7] = 7'b1111111;
    for (int i = 0; i < DIGITS; i++) mcode[i] = 0;
    mcur = 0;

    // Reset with key_b held through release
    rst_n = 1'b0;
    key_b = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_segments", {25'd0, segments}, 32'd0);
    chk("rst_digit_en", {28'd0, digit_en}, 32'd0);
    chk("rst_cursor", {30'd0, cursor}, 32'd0);
    tick(12);
    sb_seg.push_back(pat[0]);
    check_slot(0, "held_key_no_inc");
    key_b = 1'b0;
    tick(8);

    // Increment through the full range and wrap
    for (int i = 0; i < 8; i++) begin
      press(1'b0, 1'b1, 1'b0);
      check_slot(0, $sformatf("inc%0d", i + 1));
    end

    // Decrement wraps 0 -> 7
    press(1'b1, 1'b0, 1'b0);
    check_slot(0, "dec_wrap");

    // a and b together leave the code alone
    press(1'b1, 1'b1, 1'b0);
    check_slot(0, "a_and_b");

    // Cursor moves, then sel with b edits the old cursor before advancing
    press(1'b0, 1'b0, 1'b1);
    chk("cursor_sel", {30'd0, cursor}, mcur);
    press(1'b0, 1'b1, 1'b1);
    chk("cursor_selb", {30'd0, cursor}, mcur);
    check_slot(1, "selb_digit1");

    // Scan order from reset
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < DIGITS; i++) mcode[i] = 0;
    mcur = 0;
    for (int k = 0; k < 20; k++) begin
      sb_en.push_back(((k % SCAN_DIV) == 0) ? 4'b0000 : (4'b0001 << ((k / SCAN_DIV) % DIGITS)));
      tick(1);
      chk($sformatf("scan%0d", k), {28'd0, digit_en}, {28'd0, sb_en.pop_front()});
    end
    chk("cursor_after_reset", {30'd0, cursor}, mcur);

    // Bouncing key_b: 1,0,1 with 2-cycle gaps then held
    key_b = 1'b1; tick(2);
    key_b = 1'b0; tick(2);
    key_b = 1'b1; tick(6);
    key_b = 1'b0; tick(10);
`ifdef SEG_KEY_DEBOUNCE_EN
    mcode[0] = 1;
`else
    mcode[0] = 2;
`endif
    sb_seg.push_back(pat[mcode[0]]);
    check_slot(0, "bounce");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
